// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC decimator sequencer: strobes, flush and boundary-aligned rate/gain changes.
// Optional rate clamp/error flag enabled by defining CIC_DEC_CTRL_RATE_CHK_EN.
module cic_dec_ctrl #(
    parameter int addedgain_width = 3,
    parameter int FLUSH_STROBES   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       strobe_in,
    input  logic                       set_stb,
    input  logic [7:0]                 set_rate,
    input  logic [addedgain_width-1:0] set_gain,
    output logic                       cic_rst,
    output logic                       strobe_int,
    output logic                       strobe_out,
    output logic [7:0]                 rate_cur,
    output logic [addedgain_width-1:0] gain_cur,
    output logic                       busy,
    output logic                       rate_err
);

    typedef enum logic [1:0] {S_IDLE, S_RELEASE, S_FLUSH, S_RUN} state_t;

    localparam int FW = $clog2(FLUSH_STROBES + 1);

    state_t                     r_state, w_state_nxt;
    logic [7:0]                 r_dec_cnt, w_dec_cnt_nxt;
    logic [FW-1:0]              r_flush_cnt, w_flush_cnt_nxt;
    logic [7:0]                 r_rate, w_rate_nxt;
    logic [7:0]                 r_pend_rate, w_pend_rate_nxt;
    logic [addedgain_width-1:0] r_gain, w_gain_nxt;
    logic [addedgain_width-1:0] r_pend_gain, w_pend_gain_nxt;
    logic                       r_pend, w_pend_nxt;
    logic                       r_sint, w_sint_nxt;
    logic                       r_sout, w_sout_nxt;
    logic                       r_err, w_err_nxt;
    logic [7:0]                 w_set_rate_m;
    logic                       w_bad_rate;
    logic                       w_boundary;

`ifdef CIC_DEC_CTRL_RATE_CHK_EN
    assign w_bad_rate   = (set_rate == 8'd0) || (set_rate > 8'd128);
    assign w_set_rate_m = (set_rate == 8'd0) ? 8'd1 :
                          (set_rate > 8'd128) ? 8'd128 : set_rate;
`else
    assign w_bad_rate   = 1'b0;
    assign w_set_rate_m = (set_rate == 8'd0) ? 8'd1 : set_rate;
`endif

    assign w_boundary = strobe_in && (r_dec_cnt == (r_rate - 8'd1));

    always_comb begin
        w_state_nxt     = r_state;
        w_dec_cnt_nxt   = r_dec_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_rate_nxt      = r_rate;
        w_gain_nxt      = r_gain;
        w_pend_rate_nxt = r_pend_rate;
        w_pend_gain_nxt = r_pend_gain;
        w_pend_nxt      = r_pend;
        w_sint_nxt      = 1'b0;
        w_sout_nxt      = 1'b0;
        w_err_nxt       = r_err | (set_stb & w_bad_rate);

        if (!run) begin
            // Dropping run applies whatever config is newest, so IDLE always shows the active setting.
            w_state_nxt     = S_IDLE;
            w_dec_cnt_nxt   = 8'd0;
            w_flush_cnt_nxt = '0;
            w_pend_nxt      = 1'b0;
            if (set_stb) begin
                w_rate_nxt = w_set_rate_m;
                w_gain_nxt = set_gain;
            end else if (r_pend) begin
                w_rate_nxt = r_pend_rate;
                w_gain_nxt = r_pend_gain;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_dec_cnt_nxt   = 8'd0;
                    w_flush_cnt_nxt = '0;
                    if (set_stb) begin
                        w_rate_nxt = w_set_rate_m;
                        w_gain_nxt = set_gain;
                    end
                    w_state_nxt = S_RELEASE;
                end
                S_RELEASE: begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = S_FLUSH;
                end
                S_FLUSH: begin
                    if (strobe_in) begin
                        w_sint_nxt = 1'b1;
                        if (r_flush_cnt == FW'(FLUSH_STROBES - 1)) begin
                            w_state_nxt   = S_RUN;
                            w_dec_cnt_nxt = 8'd0;
                        end else begin
                            w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (strobe_in) begin
                        w_sint_nxt = 1'b1;
                        if (w_boundary) begin
                            w_sout_nxt    = 1'b1;
                            w_dec_cnt_nxt = 8'd0;
                            if (r_pend) begin
                                w_rate_nxt  = r_pend_rate;
                                w_gain_nxt  = r_pend_gain;
                                w_pend_nxt  = 1'b0;
                                w_state_nxt = S_RELEASE;
                            end
                        end else begin
                            w_dec_cnt_nxt = r_dec_cnt + 8'd1;
                        end
                    end
                end
            endcase
            // Captured after the boundary logic so a same-cycle set_stb waits for the next boundary.
            if (set_stb && (r_state != S_IDLE)) begin
                w_pend_rate_nxt = w_set_rate_m;
                w_pend_gain_nxt = set_gain;
                w_pend_nxt      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dec_cnt   <= 8'd0;
            r_flush_cnt <= '0;
            r_rate      <= 8'd1;
            r_gain      <= '0;
            r_pend_rate <= 8'd1;
            r_pend_gain <= '0;
            r_pend      <= 1'b0;
            r_sint      <= 1'b0;
            r_sout      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dec_cnt   <= w_dec_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_rate      <= w_rate_nxt;
            r_gain      <= w_gain_nxt;
            r_pend_rate <= w_pend_rate_nxt;
            r_pend_gain <= w_pend_gain_nxt;
            r_pend      <= w_pend_nxt;
            r_sint      <= w_sint_nxt;
            r_sout      <= w_sout_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign cic_rst    = (r_state == S_IDLE) || (r_state == S_RELEASE);
    assign strobe_int = r_sint;
    assign strobe_out = r_sout;
    assign rate_cur   = r_rate;
    assign gain_cur   = r_gain;
    assign busy       = (r_state != S_RUN) || r_pend;
    assign rate_err   = r_err;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - self-checking bench for cic_dec_ctrl (vector table, directed sequences, random vs model).
module tb_cic_dec_ctrl;

    localparam int FLUSH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       strobe_in = 1'b0;
    logic       set_stb = 1'b0;
    logic [7:0] set_rate = 8'd0;
    logic [2:0] set_gain = 3'd0;
    logic       cic_rst, strobe_int, strobe_out, busy, rate_err;
    logic [7:0] rate_cur;
    logic [2:0] gain_cur;

    int n_total = 0;
    int n_pass  = 0;

    cic_dec_ctrl #(.addedgain_width(3), .FLUSH_STROBES(FLUSH)) dut (
        .clk(clk), .rst(rst), .run(run), .strobe_in(strobe_in),
        .set_stb(set_stb), .set_rate(set_rate), .set_gain(set_gain),
        .cic_rst(cic_rst), .strobe_int(strobe_int), .strobe_out(strobe_out),
        .rate_cur(rate_cur), .gain_cur(gain_cur), .busy(busy), .rate_err(rate_err)
    );

    always #5 clk = ~clk;

    // Reference model: phase flags, strobes left to discard, strobes seen in the current block.
    typedef struct { int rate; int gain; } cfg_t;
    cfg_t pend_q[$];
    bit   m_idle, m_rel, m_err, m_sint, m_sout;
    int   m_flush_left, m_blk, m_rate, m_gain;

    function automatic int map_rate(input int r);
        if (r == 0) return 1;
`ifdef CIC_DEC_CTRL_RATE_CHK_EN
        if (r > 128) return 128;
`endif
        return r;
    endfunction

    function automatic bit bad_rate(input int r);
`ifdef CIC_DEC_CTRL_RATE_CHK_EN
        return (r == 0) || (r > 128);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input int r, input int ru, input int s, input int ss,
                              input int rate, input int gain);
        cfg_t nc;
        nc.rate = map_rate(rate);
        nc.gain = gain & 7;
        if (r != 0) begin
            m_idle = 1; m_rel = 0; m_flush_left = 0; m_blk = 0;
            m_rate = 1; m_gain = 0; m_err = 0; m_sint = 0; m_sout = 0;
            pend_q.delete();
            return;
        end
        m_sint = 0;
        m_sout = 0;
        if (ss != 0 && bad_rate(rate)) m_err = 1;
        if (ru == 0) begin
            if (ss != 0) begin
                m_rate = nc.rate; m_gain = nc.gain;
            end else if (pend_q.size() > 0) begin
                m_rate = pend_q[0].rate; m_gain = pend_q[0].gain;
            end
            pend_q.delete();
            m_idle = 1; m_rel = 0; m_flush_left = 0; m_blk = 0;
        end else if (m_idle) begin
            if (ss != 0) begin
                m_rate = nc.rate; m_gain = nc.gain;
            end
            m_idle = 0;
            m_rel  = 1;
        end else begin
            if (m_rel) begin
                m_rel = 0;
                m_flush_left = FLUSH;
            end else if (m_flush_left > 0) begin
                if (s != 0) begin
                    m_sint = 1;
                    m_flush_left--;
                    m_blk = 0;
                end
            end else if (s != 0) begin
                m_sint = 1;
                m_blk++;
                if (m_blk == m_rate) begin
                    m_sout = 1;
                    m_blk  = 0;
                    if (pend_q.size() > 0) begin
                        m_rate = pend_q[0].rate; m_gain = pend_q[0].gain;
                        pend_q.delete();
                        m_rel = 1;
                    end
                end
            end
            if (ss != 0) begin
                pend_q.delete();
                pend_q.push_back(nc);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int r, input int ru, input int s, input int ss,
                        input int rate, input int gain);
        rst       = (r != 0);
        run       = (ru != 0);
        strobe_in = (s != 0);
        set_stb   = (ss != 0);
        set_rate  = 8'(rate);
        set_gain  = 3'(gain);
        @(posedge clk);
        #1;
        model_step(r, ru, s, ss, rate, gain);
        check("cic_rst",    int'(cic_rst),    int'(m_idle || m_rel));
        check("strobe_int", int'(strobe_int), int'(m_sint));
        check("strobe_out", int'(strobe_out), int'(m_sout));
        check("rate_cur",   int'(rate_cur),   m_rate);
        check("gain_cur",   int'(gain_cur),   m_gain);
        check("busy",       int'(busy),       int'(m_idle || m_rel || m_flush_left > 0 || pend_q.size() > 0));
        check("rate_err",   int'(rate_err),   int'(m_err));
    endtask

    typedef struct {
        int rst_i, run_i, stb_i, set_i, rate_i, gain_i;
        int e_cic, e_sint, e_sout, e_rate, e_busy;
    } vec_t;
    vec_t vecs[20];

    initial begin
        int found, cnt;

        vecs[0] = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1};
        vecs[1] = '{0, 0, 0, 1, 4, 1,  1, 0, 0, 4, 1};
        vecs[2] = '{0, 1, 1, 0, 0, 0,  1, 0, 0, 4, 1};
        vecs[3] = '{0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 1};
        for (int i = 4; i < 12; i++)
            vecs[i] = '{0, 1, 1, 0, 0, 0,  0, 1, 0, 4, (i == 11) ? 0 : 1};
        for (int i = 12; i < 20; i++)
            vecs[i] = '{0, 1, 1, 0, 0, 0,  0, 1, ((i % 4) == 3) ? 1 : 0, 4, 0};

        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].rst_i, vecs[i].run_i, vecs[i].stb_i, vecs[i].set_i,
                 vecs[i].rate_i, vecs[i].gain_i);
            check($sformatf("vec%0d_cic_rst", i),    int'(cic_rst),    vecs[i].e_cic);
            check($sformatf("vec%0d_strobe_int", i), int'(strobe_int), vecs[i].e_sint);
            check($sformatf("vec%0d_strobe_out", i), int'(strobe_out), vecs[i].e_sout);
            check($sformatf("vec%0d_rate_cur", i),   int'(rate_cur),   vecs[i].e_rate);
            check($sformatf("vec%0d_busy", i),       int'(busy),       vecs[i].e_busy);
        end

        // Rate change requested mid-block waits for the boundary.
        tick(0, 1, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 8, 2);
        check("chg_rate_held", int'(rate_cur), 4);
        check("chg_busy_pending", int'(busy), 1);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            if (strobe_out) begin found = 1; break; end
        end
        check("chg_boundary_seen", found, 1);
        check("chg_rate_applied", int'(rate_cur), 8);
        check("chg_gain_applied", int'(gain_cur), 2);
        check("chg_release_rst", int'(cic_rst), 1);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            if (strobe_out) cnt++;
        end
        check("chg_outs_rate8", cnt, 2);

        // Two requests before a boundary: last one wins.
        tick(0, 1, 1, 1, 3, 1);
        check("two_busy", int'(busy), 1);
        tick(0, 1, 0, 1, 5, 4);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            if (strobe_out) begin found = 1; break; end
        end
        check("two_boundary_seen", found, 1);
        check("two_rate_last", int'(rate_cur), 5);
        for (int k = 0; k < 9; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            if (k < 8) check("two_busy_hold", int'(busy), 1);
        end
        check("two_busy_run", int'(busy), 0);

        // set_rate=0 maps to 1: every strobe is a boundary.
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 3);
        check("r0_rate_one", int'(rate_cur), 1);
        for (int k = 0; k < 10; k++) tick(0, 1, 1, 0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            if (strobe_out) cnt++;
        end
        check("r0_every_strobe", cnt, 5);

        // Sparse strobes, run dropped, then rst during flush.
        tick(0, 0, 0, 1, 3, 6);
        for (int k = 0; k < 40; k++) tick(0, 1, (k % 3 == 0) ? 1 : 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        check("drop_no_sint", int'(strobe_int), 0);
        check("drop_cic_rst", int'(cic_rst), 1);
        for (int k = 0; k < 4; k++) tick(0, 1, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0);
        check("rst_flush_cic", int'(cic_rst), 1);
        check("rst_flush_sint", int'(strobe_int), 0);
        check("rst_flush_rate", int'(rate_cur), 1);
        check("rst_flush_gain", int'(gain_cur), 0);
        check("rst_flush_busy", int'(busy), 1);

        // Out-of-range rate.
        tick(0, 0, 0, 1, 200, 5);
`ifdef CIC_DEC_CTRL_RATE_CHK_EN
        check("r200_rate", int'(rate_cur), 128);
        check("r200_err", int'(rate_err), 1);
        tick(0, 0, 0, 1, 4, 0);
        check("r200_err_sticky", int'(rate_err), 1);
`else
        check("r200_rate", int'(rate_cur), 200);
        check("r200_err", int'(rate_err), 0);
`endif
        tick(1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            int rsel, rv;
            rsel = $urandom_range(0, 9);
            case (rsel)
                0: rv = 0;
                1: rv = 1;
                2: rv = 2;
                3: rv = 3;
                4: rv = 4;
                5: rv = 5;
                6: rv = 7;
                7: rv = 8;
                8: rv = 200;
                default: rv = $urandom_range(0, 255);
            endcase
            tick(($urandom_range(0, 299) == 0) ? 1 : 0,
                 ($urandom_range(0, 149) != 0) ? 1 : 0,
                 $urandom_range(0, 1),
                 ($urandom_range(0, 39) == 0) ? 1 : 0,
                 rv, $urandom_range(0, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
